ahb_lite_rr_master: RTL and testbench

Round-robin AHB-Lite master that shares one AHB-Lite slave port (the on-chip word memory) between `NUM_REQ` simple request/acknowledge clients. It arbitrates between the clients, issues single 32-bit NONSEQ transfers, and returns read data and an error flag to the granted client. It guards against a hung slave with a timeout and rejects misaligned addresses before any bus activity. It sits between the testbench/client agents and the AHB-Lite slave interface.

---
 rtl/ahb_lite_rr_master.sv | 199 +++++++++++++++++++
 tb/tb_ahb_lite_rr_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_rr_master.sv
// Round-robin AHB-Lite master: shares one slave port between NUM_REQ req/ack
// clients, issuing single-word NONSEQ transfers with a data-phase timeout.
`timescale 1ns/1ps
module ahb_lite_rr_master #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [NUM_REQ*32-1:0] addr,
  input  logic [NUM_REQ*32-1:0] wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic                  busy,
  output logic                  HSEL,
  output logic [31:0]           HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [31:0]           HWDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP,
  input  logic [31:0]           HRDATA
);

  localparam int               IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);
  localparam logic [7:0]       TIMEOUT_C    = 8'(TIMEOUT);
  localparam logic [1:0]       TRANS_IDLE   = 2'b00;
  localparam logic [1:0]       TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   last_grant_r;
  logic [IDX_W-1:0]   grant_r;
  logic [7:0]         cnt_r;
  logic               hsel_r;
  logic [31:0]        haddr_r;
  logic [1:0]         htrans_r;
  logic               hwrite_r;
  logic [31:0]        hwdata_r;
  logic [NUM_REQ-1:0] ack_r;
  logic               err_r;
  logic [31:0]        rdata_r;
  logic               busy_r;

  logic [2*NUM_REQ-1:0] req_dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic                 any_req_s;
  logic [IDX_W-1:0]     winner_s;
  logic                 win_we_s;
  logic [31:0]          win_addr_s;
  logic [31:0]          win_wdata_s;
  logic                 unused_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      vec[k] = (idx == IDX_W'(k));
    end
    return vec;
  endfunction

  // Round-robin pick: rotate req so that position 0 is last_grant+1, take the first set bit.
  always_comb begin
    req_dbl_s   = {req, req} >> (int'(last_grant_r) + 1);
    rot_s       = req_dbl_s[NUM_REQ-1:0];
    any_req_s   = 1'b0;
    winner_s    = '0;
    win_we_s    = 1'b0;
    win_addr_s  = 32'h0000_0000;
    win_wdata_s = 32'h0000_0000;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req_s && rot_s[k]) begin
        any_req_s = 1'b1;
        winner_s  = IDX_W'((int'(last_grant_r) + 1 + k) % NUM_REQ);
      end else begin
        any_req_s = any_req_s;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner_s == IDX_W'(k)) begin
        win_we_s    = we[k];
        win_addr_s  = addr[32*k +: 32];
        win_wdata_s = wdata[32*k +: 32];
      end else begin
        win_we_s = win_we_s;
      end
    end
  end

  // Transfer FSM; every bus and client output is a register updated here.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r      <= IDLE;
      last_grant_r <= LAST_IDX;
      grant_r      <= '0;
      cnt_r        <= 8'd0;
      hsel_r       <= 1'b0;
      haddr_r      <= 32'h0000_0000;
      htrans_r     <= TRANS_IDLE;
      hwrite_r     <= 1'b0;
      hwdata_r     <= 32'h0000_0000;
      ack_r        <= '0;
      err_r        <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      busy_r       <= 1'b0;
    end else begin
      ack_r <= '0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r      <= winner_s;
            last_grant_r <= winner_s;
            busy_r       <= 1'b1;
            if (win_addr_s[1:0] != 2'b00) begin
              // Misaligned: answer straight away, never touch the bus.
              state_r <= RESP;
              ack_r   <= onehot(winner_s);
              err_r   <= 1'b1;
              rdata_r <= 32'h0000_0000;
            end else begin
              state_r  <= ADDR;
              hsel_r   <= 1'b1;
              htrans_r <= TRANS_NONSEQ;
              haddr_r  <= win_addr_s;
              hwrite_r <= win_we_s;
              hwdata_r <= win_wdata_s;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ADDR: begin
          state_r  <= DATA;
          hsel_r   <= 1'b0;
          htrans_r <= TRANS_IDLE;
          cnt_r    <= 8'd0;
        end
        DATA: begin
          if (HREADY) begin
            state_r <= RESP;
            ack_r   <= onehot(grant_r);
            err_r   <= HRESP[0];
            rdata_r <= hwrite_r ? 32'h0000_0000 : HRDATA;
          end else if ((cnt_r + 8'd1) >= TIMEOUT_C) begin
            state_r <= RESP;
            ack_r   <= onehot(grant_r);
            err_r   <= 1'b1;
            rdata_r <= 32'h0000_0000;
            cnt_r   <= cnt_r + 8'd1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        RESP: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= 32'h0000_0000;
          cnt_r   <= 8'd0;
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          hsel_r   <= 1'b0;
          htrans_r <= TRANS_IDLE;
          cnt_r    <= 8'd0;
        end
      endcase
    end
  end

  assign unused_s = HRESP[1];

  assign HSEL   = hsel_r;
  assign HADDR  = haddr_r;
  assign HTRANS = htrans_r;
  assign HWRITE = hwrite_r;
  assign HWDATA = hwdata_r;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign ack    = ack_r;
  assign err    = err_r;
  assign rdata  = rdata_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_ahb_lite_rr_master.sv
// Directed bench for ahb_lite_rr_master with a small word-memory slave whose
// wait states and response code are set per scenario.
`timescale 1ns/1ps
module tb_ahb_lite_rr_master;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 16;

  logic                  HCLK = 1'b0;
  logic                  HRESET;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ*32-1:0] addr;
  logic [NUM_REQ*32-1:0] wdata;
  logic [NUM_REQ-1:0]    ack;
  logic                  err;
  logic [31:0]           rdata;
  logic                  busy;
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [31:0]           HWDATA;
  logic                  HREADY;
  logic [1:0]            HRESP;
  logic [31:0]           HRDATA;

  always #5 HCLK = ~HCLK;

  ahb_lite_rr_master #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  int total = 0;
  int bad   = 0;

  // Slave model, evaluated on the falling edge: address accepted at a rising
  // edge where NONSEQ is shown, data phase ends at a rising edge with HREADY=1.
  logic [31:0] mem [0:63];
  bit          pending, dphase, dp_write, pend_write;
  logic [5:0]  dp_idx, pend_idx;
  int          wait_cfg = 0;
  int          waits_left = 0;
  bit          stall = 1'b0;
  logic [1:0]  resp_cfg = 2'b00;

  always @(negedge HCLK) begin
    if (HRESET) begin
      pending = 1'b0; dphase = 1'b0;
      HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
    end else begin
      if (dphase && HREADY) begin
        if (dp_write) mem[dp_idx] = HWDATA;
        dphase = 1'b0;
      end
      if (pending) begin
        dphase = 1'b1; dp_idx = pend_idx; dp_write = pend_write; waits_left = wait_cfg;
      end
      pending    = HSEL && (HTRANS == 2'b10);
      pend_idx   = HADDR[7:2];
      pend_write = HWRITE;
      if (dphase && (stall || waits_left > 0)) begin
        HREADY = 1'b0; HRESP = 2'b00; HRDATA = 32'h0;
        if (waits_left > 0) waits_left--;
      end else if (dphase) begin
        HREADY = 1'b1; HRESP = resp_cfg; HRDATA = dp_write ? 32'h0 : mem[dp_idx];
      end else begin
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
      end
    end
  end

  // One client transfer; cycle 1 is the first cycle after the request is sampled.
  task automatic run_xfer(input int c, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int ack_cyc, output logic [NUM_REQ-1:0] ack_v, output logic e,
                          output logic [31:0] rd, output int ntrans, output logic [31:0] ns_addr,
                          output logic ns_write, output logic [31:0] ns_wdata, output logic hsel_any);
    @(negedge HCLK);
    req = '0; req[c] = 1'b1; we[c] = w; addr[32*c +: 32] = a; wdata[32*c +: 32] = d;
    ack_cyc = -1; ack_v = '0; e = 1'b0; rd = 32'h0; ntrans = 0;
    ns_addr = 32'h0; ns_write = 1'b0; ns_wdata = 32'h0; hsel_any = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge HCLK);
      if (HSEL) hsel_any = 1'b1;
      if (HTRANS == 2'b10) begin
        ntrans++; ns_addr = HADDR; ns_write = HWRITE; ns_wdata = HWDATA;
      end
      if (ack != '0) begin
        ack_cyc = k; ack_v = ack; e = err; rd = rdata;
        break;
      end
    end
    req = '0;
  endtask

  task automatic apply_reset();
    @(negedge HCLK);
    HRESET = 1'b1; req = '0;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge HCLK);
    total++; if (HSEL !== 1'b0 || HTRANS !== 2'b00 || HWRITE !== 1'b0) begin bad++; $display("FAIL reset_bus_ctrl got=%b/%b/%b want=0/00/0", HSEL, HTRANS, HWRITE); end
    total++; if (HADDR !== 32'h0 || HWDATA !== 32'h0) begin bad++; $display("FAIL reset_bus_data got=%h/%h want=0/0", HADDR, HWDATA); end
    total++; if (ack !== 2'b00 || err !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0) begin bad++; $display("FAIL reset_client got=%b/%b/%h/%b want=00/0/0/0", ack, err, rdata, busy); end
    total++; if (HSIZE !== 3'b010 || HBURST !== 3'b000) begin bad++; $display("FAIL reset_size_burst got=%b/%b want=010/000", HSIZE, HBURST); end
    HRESET = 1'b0;
  endtask

  task automatic test_basic_rw();
    int ac, nt; logic [1:0] av; logic e, nw, hs; logic [31:0] rd, na, nd;
    run_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, ac, av, e, rd, nt, na, nw, nd, hs);
    total++; if (ac !== 3) begin bad++; $display("FAIL wr_ack_cycle got=%0d want=3", ac); end
    total++; if (av !== 2'b01 || e !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL wr_resp got=%b/%b/%h want=01/0/0", av, e, rd); end
    total++; if (nt !== 1 || na !== 32'h10 || nw !== 1'b1 || nd !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_addr_phase got=%0d/%h/%b/%h want=1/10/1/deadbeef", nt, na, nw, nd); end
    @(negedge HCLK);
    total++; if (ack !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL wr_idle_after got=%b/%b want=00/0", ack, busy); end
    run_xfer(0, 1'b0, 32'h10, 32'h0, ac, av, e, rd, nt, na, nw, nd, hs);
    total++; if (ac !== 3 || av !== 2'b01) begin bad++; $display("FAIL rd_ack got=%0d/%b want=3/01", ac, av); end
    total++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin bad++; $display("FAIL rd_data got=%h/%b want=deadbeef/0", rd, e); end
    total++; if (nt !== 1 || nw !== 1'b0) begin bad++; $display("FAIL rd_addr_phase got=%0d/%b want=1/0", nt, nw); end
  endtask

  task automatic test_back_to_back();
    int ac_a[4]; logic [1:0] av_a[4]; logic [31:0] ha_a[4];
    int na = 0; int nn = 0;
    logic [1:0] exp_v[4]; logic [31:0] exp_a[4];
    exp_v = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_a = '{32'h20, 32'h24, 32'h20, 32'h24};
    for (int i = 0; i < 4; i++) begin ac_a[i] = -1; av_a[i] = 2'b00; ha_a[i] = 32'h0; end
    apply_reset();
    @(negedge HCLK);
    req = 2'b11; we = 2'b11; addr = {32'h24, 32'h20}; wdata = {32'hB1B1B1B1, 32'hA0A0A0A0};
    for (int k = 1; k <= 40 && na < 4; k++) begin
      @(negedge HCLK);
      if (HTRANS == 2'b10 && nn < 4) begin ha_a[nn] = HADDR; nn++; end
      if (ack != 2'b00) begin ac_a[na] = k; av_a[na] = ack; na++; end
    end
    req = '0;
    total++; if (na !== 4 || nn !== 4) begin bad++; $display("FAIL b2b_count got=%0d/%0d want=4/4", na, nn); end
    for (int i = 0; i < 4; i++) begin
      total++; if (ac_a[i] !== 3 + 4*i || av_a[i] !== exp_v[i]) begin bad++; $display("FAIL b2b_ack%0d got=%0d/%b want=%0d/%b", i, ac_a[i], av_a[i], 3 + 4*i, exp_v[i]); end
      total++; if (ha_a[i] !== exp_a[i]) begin bad++; $display("FAIL b2b_haddr%0d got=%h want=%h", i, ha_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_misaligned();
    int ac, nt; logic [1:0] av; logic e, nw, hs; logic [31:0] rd, na, nd;
    run_xfer(1, 1'b0, 32'h13, 32'h0, ac, av, e, rd, nt, na, nw, nd, hs);
    total++; if (ac !== 1 || av !== 2'b10 || e !== 1'b1) begin bad++; $display("FAIL mis_ack got=%0d/%b/%b want=1/10/1", ac, av, e); end
    total++; if (nt !== 0 || hs !== 1'b0) begin bad++; $display("FAIL mis_no_bus got=%0d/%b want=0/0", nt, hs); end
    @(negedge HCLK);
    total++; if (busy !== 1'b0 || HTRANS !== 2'b00 || HSEL !== 1'b0 || ack !== 2'b00) begin bad++; $display("FAIL mis_idle got=%b/%b/%b/%b want=0/00/0/00", busy, HTRANS, HSEL, ack); end
  endtask

  task automatic test_timeout();
    int ac, nt; logic [1:0] av; logic e, nw, hs; logic [31:0] rd, na, nd;
    stall = 1'b1;
    run_xfer(0, 1'b0, 32'h10, 32'h0, ac, av, e, rd, nt, na, nw, nd, hs);
    stall = 1'b0;
    total++; if (ac !== 2 + TIMEOUT || av !== 2'b01) begin bad++; $display("FAIL to_ack got=%0d/%b want=%0d/01", ac, av, 2 + TIMEOUT); end
    total++; if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL to_err got=%b/%h want=1/0", e, rd); end
    run_xfer(0, 1'b0, 32'h10, 32'h0, ac, av, e, rd, nt, na, nw, nd, hs);
    total++; if (ac !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL to_recover got=%0d/%b/%h want=3/0/deadbeef", ac, e, rd); end
    wait_cfg = 2;
    run_xfer(0, 1'b0, 32'h10, 32'h0, ac, av, e, rd, nt, na, nw, nd, hs);
    total++; if (ac !== 5 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL wait2 got=%0d/%b/%h want=5/0/deadbeef", ac, e, rd); end
    wait_cfg = TIMEOUT - 1;
    run_xfer(0, 1'b0, 32'h10, 32'h0, ac, av, e, rd, nt, na, nw, nd, hs);
    wait_cfg = 0;
    total++; if (ac !== 2 + TIMEOUT || e !== 1'b0 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL wait_max got=%0d/%b/%h want=%0d/0/deadbeef", ac, e, rd, 2 + TIMEOUT); end
  endtask

  task automatic test_hresp_err();
    int ac, nt; logic [1:0] av; logic e, nw, hs; logic [31:0] rd, na, nd;
    resp_cfg = 2'b01;
    run_xfer(0, 1'b0, 32'h10, 32'h0, ac, av, e, rd, nt, na, nw, nd, hs);
    resp_cfg = 2'b00;
    total++; if (ac !== 3 || av !== 2'b01 || e !== 1'b1) begin bad++; $display("FAIL hresp_err got=%0d/%b/%b want=3/01/1", ac, av, e); end
  endtask

  task automatic test_reset_mid();
    int ac = -1; logic [1:0] av = 2'b00; logic [31:0] ha = 32'h0; bit seen_ack = 1'b0;
    stall = 1'b1;
    @(negedge HCLK);
    req = 2'b01; we = 2'b01; addr[31:0] = 32'h30; wdata[31:0] = 32'h12345678;
    @(negedge HCLK);
    total++; if (HTRANS !== 2'b10 || HWDATA !== 32'h12345678) begin bad++; $display("FAIL rm_inflight got=%b/%h want=10/12345678", HTRANS, HWDATA); end
    @(negedge HCLK);
    total++; if (busy !== 1'b1 || HTRANS !== 2'b00) begin bad++; $display("FAIL rm_data got=%b/%b want=1/00", busy, HTRANS); end
    HRESET = 1'b1; req = '0;
    @(negedge HCLK);
    total++; if (HSEL !== 1'b0 || HADDR !== 32'h0 || HTRANS !== 2'b00 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin bad++; $display("FAIL rm_bus got=%b/%h/%b/%b/%h want=0/0/00/0/0", HSEL, HADDR, HTRANS, HWRITE, HWDATA); end
    total++; if (ack !== 2'b00 || err !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0 || HSIZE !== 3'b010) begin bad++; $display("FAIL rm_client got=%b/%b/%h/%b/%b want=00/0/0/0/010", ack, err, rdata, busy, HSIZE); end
    stall = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    req = 2'b11; we = 2'b00; addr = {32'h44, 32'h40};
    for (int k = 1; k <= 20 && !seen_ack; k++) begin
      @(negedge HCLK);
      if (HTRANS == 2'b10) ha = HADDR;
      if (ack != 2'b00) begin ac = k; av = ack; seen_ack = 1'b1; end
    end
    req = '0;
    total++; if (ac !== 3 || av !== 2'b01 || ha !== 32'h40) begin bad++; $display("FAIL rm_first_grant got=%0d/%b/%h want=3/01/40", ac, av, ha); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_basic_rw();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_hresp_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
